// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared types and constants for the ALU issue controller
package alu_issue_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NREG_DEF   = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_rf.sv
// rtl/alu_issue_rf.sv - register file, two async read ports, one sync write port, sync clear
module alu_issue_rf #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [$clog2(NREG)-1:0] raddr_a,
  output logic [DATA_W-1:0]       rdata_a,
  input  logic [$clog2(NREG)-1:0] raddr_b,
  output logic [DATA_W-1:0]       rdata_b
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue ALU sequencer: accept, execute on external ALU, write back
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [2:0]              instr_op,
  input  logic [$clog2(NREG)-1:0] instr_rd,
  input  logic [$clog2(NREG)-1:0] instr_rs1,
  input  logic [$clog2(NREG)-1:0] instr_rs2,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [2:0]              alu_op,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    alu_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_result,
  output logic                    out_zero,
  output logic [$clog2(NREG)-1:0] out_rd,
  output logic [7:0]              op_count
);

  localparam int AW = $clog2(NREG);

  state_t state, state_next;
  logic [2:0]        op_q;
  logic [AW-1:0]     rd_q, rs1_q, rs2_q;
  logic              accept, retire;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata, rdata_a, rdata_b;

  assign accept = instr_valid & instr_ready;
  assign retire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      if (retire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    out_valid   = (state == WB);
    alu_op      = '0;
    alu_a       = '0;
    alu_b       = '0;
    if (state == EXEC) begin
      alu_op = op_q;
      alu_a  = rdata_a;
      alu_b  = rdata_b;
    end
  end

  // Host writes own the write port in IDLE; the ALU result owns it in EXEC.
  // Reading rs1/rs2 is asynchronous, so sources are seen before the EXEC-edge write.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wr_addr;
    rf_wdata = wr_data;
    if (state == EXEC) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = alu_result;
    end else if (state == IDLE) begin
      rf_we    = wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_rd     <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
      end
      if (state == EXEC) begin
        out_result <= alu_result;
        out_zero   <= alu_zero;
        out_rd     <= rd_q;
      end
      if (retire) op_count <= op_count + 8'd1;
    end
  end

  alu_issue_rf #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs1_q),
    .rdata_a (rdata_a),
    .raddr_b (rs2_q),
    .rdata_b (rdata_b)
  );

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: operand and result width.
REQ-002 Parameter NREG, default 4: register-file depth; address width is log2(NREG) = 2.
REQ-003 Clock is clk and reset is rst; rst is synchronous and active-high; there is a single clock domain.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 instr_valid  in  1  instruction offered.
REQ-007 instr_ready  out  1  instruction accepted when high together with instr_valid.
REQ-008 instr_op  in  3  ALU op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 LT, 111 SHL.
REQ-009 instr_rd / instr_rs1 / instr_rs2  in  2 each  destination and source register indices.
REQ-010 wr_en, wr_addr[1:0], wr_data[7:0]  in  host register preload port.
REQ-011 alu_op[2:0], alu_a[7:0], alu_b[7:0]  out  drive the downstream combinational ALU.
REQ-012 alu_result[7:0], alu_zero  in  ALU result and zero flag, returned in the same cycle.
REQ-013 out_valid  out  1  completion record available.
REQ-014 out_ready  in  1  consumer accepts the completion record.
REQ-015 out_result[7:0], out_zero, out_rd[1:0]  out  completion record fields.
REQ-016 op_count[7:0]  out  count of completed instructions.

Function
REQ-017 The FSM shall have three states, IDLE, EXEC and WB, with these transitions:
- IDLE -> EXEC on instr_valid & instr_ready.
- EXEC -> WB unconditionally.
- WB -> IDLE on out_valid & out_ready.
REQ-018 instr_ready shall be 1 only in IDLE, and out_valid shall be 1 only in WB.
REQ-019 On acceptance, op, rd, rs1 and rs2 shall be latched; later changes on the instr_* inputs shall have no effect until the next acceptance.
REQ-020 In EXEC, alu_op shall equal the latched op, alu_a shall equal rf[rs1] and alu_b shall equal rf[rs2]; outside EXEC all three shall be 0.
REQ-021 At the EXEC clock edge, the block shall:
- capture alu_result and alu_zero into out_result and out_zero;
- capture rd into out_rd;
- write alu_result into rf[rd].
REQ-022 Latency: for an accept edge at cycle N, out_valid shall be high from cycle N+2, and the register write shall be visible from cycle N+2.
REQ-023 In WB with out_ready low, out_valid and all out_* fields shall hold stable, and no new instruction shall be accepted.
REQ-024 op_count shall increment by 1 on each out handshake and shall wrap from 0xFF to 0x00.
REQ-025 A host write (wr_en) shall take effect only in IDLE; in EXEC or WB it shall be dropped silently.
REQ-026 A host write and an instruction accept in the same IDLE cycle shall both take effect, and the instruction shall read the newly written value in EXEC.
REQ-027 rs1 == rs2 == rd is legal; the sources shall be read before the write.
REQ-028 Minimum throughput is one instruction per 3 cycles.

Reset
REQ-029 When rst is high at a clock edge, the block shall clear:
- state to IDLE;
- all rf entries to 0x00;
- out_result, out_zero, out_rd and op_count to 0.
REQ-030 After reset, instr_ready shall be 1, out_valid shall be 0, and alu_op, alu_a and alu_b shall be 0.
REQ-031 Reset asserted in EXEC or WB shall abort the instruction: no register write and no op_count increment.

Structure
REQ-032 Package alu_issue_pkg shall hold the state enum (IDLE, EXEC, WB), the op-code localparams OP_ADD through OP_SHL, and DATA_W_DEF = 8.
REQ-033 The register file shall be a sub-module, alu_issue_rf, with 4x8 entries, two asynchronous read ports, one synchronous write port and synchronous clear.

Verification
REQ-034 ADD: preload r0 = 0x05 and r1 = 0x03, then issue ADD rd=2, rs1=0, rs2=1. Required response at accept+2: out_valid = 1, out_result = 0x08, out_zero = 0, out_rd = 2, and r2 reads back 0x08.
REQ-035 SUB to zero: with r1 = 0x03, issue SUB rd=3, rs1=1, rs2=1. Required response: out_result = 0x00, out_zero = 1, r3 = 0x00, and op_count increments by 1.
REQ-036 Backpressure: hold out_ready low for 4 cycles in WB. Required response: out_valid stays 1, the out_* fields are unchanged, instr_ready stays 0, and exactly one handshake occurs when out_ready rises.
REQ-037 Host write outside IDLE: assert wr_en with r0 <= 0xAA during EXEC. Required response: r0 is unchanged; a same-cycle IDLE write plus accept makes EXEC see the new value on alu_a.
REQ-038 Reset mid-operation: assert rst in EXEC. Required response: on the next cycle state is IDLE, out_valid = 0, rf is all 0x00 and op_count = 0.
REQ-039 Counter wrap: complete 256 instructions. Required response: op_count returns to 0x00.
